// File: rtl/lc3_isdu_fsm.sv
// lc3_isdu_fsm: LC-3 instruction sequencer (Moore FSM).
// Drives datapath loads, bus gates, mux selects and memory strobes for
// fetch/decode/execute of ADD, AND, NOT, BR, JMP, JSR, LDR, STR.
// Optional feature macro: LC3_ISDU_PAUSE_EN (PAUSE opcode 1101, LD_LED, Continue).
module lc3_isdu_fsm #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    typedef enum logic [4:0] {
        StHalted, St18, St33, St35, St32, St1, St5, St9, St0, St22, St12,
        St4, St21, St6, St25, St27, St7, St23, St16, St13a, St13b
    } state_e;

    // Last count value of a memory access; the access lasts MEM_WAIT cycles.
    localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       wait_done;

    // Only opcode, IR[11] and IR[5] steer the sequencer.
    logic unused_ir;
    assign unused_ir = ^{IR[10:6], IR[4:0]};
`ifndef LC3_ISDU_PAUSE_EN
    logic unused_cont;
    assign unused_cont = Continue;
`endif

    assign wait_done = (wait_q == WaitLast);

    // State and access-wait counter registers.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state_q <= StHalted;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; the counter only advances inside memory-access states.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            StHalted: if (Run) state_d = St18;
            St18:     state_d = St33;
            St33:     if (wait_done) state_d = St35; else wait_d = wait_q + 4'd1;
            St35:     state_d = St32;
            St32: begin
                case (IR[15:12])
                    4'b0001: state_d = St1;
                    4'b0101: state_d = St5;
                    4'b1001: state_d = St9;
                    4'b0000: state_d = St0;
                    4'b1100: state_d = St12;
                    4'b0100: state_d = IR[11] ? St4 : St18;
                    4'b0110: state_d = St6;
                    4'b0111: state_d = St7;
`ifdef LC3_ISDU_PAUSE_EN
                    4'b1101: state_d = St13a;
`endif
                    default: state_d = St18;
                endcase
            end
            St1, St5, St9: state_d = St18;
            St0:      state_d = BEN ? St22 : St18;
            St22:     state_d = St18;
            St12:     state_d = St18;
            St4:      state_d = St21;
            St21:     state_d = St18;
            St6:      state_d = St25;
            St25:     if (wait_done) state_d = St27; else wait_d = wait_q + 4'd1;
            St27:     state_d = St18;
            St7:      state_d = St23;
            St23:     state_d = St16;
            St16:     if (wait_done) state_d = St18; else wait_d = wait_q + 4'd1;
`ifdef LC3_ISDU_PAUSE_EN
            St13a:    if (Continue) state_d = St13b;
            St13b:    if (!Continue) state_d = St18;
`endif
            default:  state_d = StHalted;
        endcase
    end

    // Moore output decode; everything defaults to 0.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
        MIO_EN = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        case (state_q)
            St18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            St33, St25: begin Mem_OE = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1; end
            St35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            St32: LD_BEN = 1'b1;
            St1, St5, St9: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                SR1MUX = 1'b1; SR2MUX = IR[5];
                ALUK = (state_q == St1) ? 2'b00 : (state_q == St5) ? 2'b01 : 2'b10;
            end
            St22: begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
            St12: begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
            St4:  begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            St21: begin ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; end
            St6, St7: begin
                GateMARMUX = 1'b1; SR1MUX = 1'b1; ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b01; LD_MAR = 1'b1;
            end
            St27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            St23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
            St16: Mem_WE = 1'b1;
`ifdef LC3_ISDU_PAUSE_EN
            St13a, St13b: LD_LED = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu_fsm.sv
// tb_lc3_isdu_fsm: scoreboard bench for lc3_isdu_fsm.
// Expected per-cycle output vectors are queued when an instruction is driven
// and popped/compared on each falling clock edge.
// Honours LC3_ISDU_PAUSE_EN the same way the design does.
module tb_lc3_isdu_fsm;
    localparam int unsigned MW = 3;

    localparam int SHalt = 0,  S18 = 1,  S33 = 2,  S35 = 3,  S32 = 4,  S1 = 5,  S5 = 6;
    localparam int S9 = 7,     S0 = 8,   S22 = 9,  S12 = 10, S4 = 11,  S21 = 12;
    localparam int S6 = 13,    S25 = 14, S27 = 15, S7 = 16,  S23 = 17, S16 = 18;
    localparam int S13a = 19,  S13b = 20;

    logic        Clk = 1'b0;
    logic        Reset_al, Run, Continue, BEN;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

    typedef struct {
        logic [24:0] vec;
        logic        cont;
    } exp_t;
    exp_t q[$];

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] cur_ir;
    logic [24:0] obs_vec;

    lc3_isdu_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
        .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    assign obs_vec = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                      GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                      DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE};

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: outputs %b, required %b (t=%0t)", tag, obs, exp, $time);
    endtask

    // Required output vector for a state, written from the control-word table.
    function automatic logic [24:0] exp_vec(input int st, input logic [15:0] ir);
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic g_pc, g_mdr, g_alu, g_marmux, drmux, sr1, sr2, a1, mio, oe, we;
        logic [1:0] pcmux, a2, aluk;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = 8'h00;
        {g_pc, g_mdr, g_alu, g_marmux, drmux, sr1, sr2, a1, mio, oe, we} = 11'h000;
        pcmux = 2'b00; a2 = 2'b00; aluk = 2'b00;
        case (st)
            S18: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            S33: begin oe = 1; ld_mdr = 1; mio = 1; end
            S35: begin g_mdr = 1; ld_ir = 1; end
            S32: ld_ben = 1;
            S1:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = ir[5]; aluk = 2'b00; end
            S5:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = ir[5]; aluk = 2'b01; end
            S9:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = ir[5]; aluk = 2'b10; end
            S22: begin a2 = 2'b10; pcmux = 2'b10; ld_pc = 1; end
            S12: begin sr1 = 1; a1 = 1; pcmux = 2'b10; ld_pc = 1; end
            S4:  begin g_pc = 1; drmux = 1; ld_reg = 1; end
            S21: begin a2 = 2'b11; pcmux = 2'b10; ld_pc = 1; end
            S6, S7: begin g_marmux = 1; sr1 = 1; a1 = 1; a2 = 2'b01; ld_mar = 1; end
            S25: begin oe = 1; ld_mdr = 1; mio = 1; end
            S27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            S23: begin aluk = 2'b11; g_alu = 1; ld_mdr = 1; end
            S16: we = 1;
            S13a, S13b: ld_led = 1;
            default: ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                g_pc, g_mdr, g_alu, g_marmux, pcmux, a2, aluk,
                drmux, sr1, sr2, a1, mio, oe, we};
    endfunction

    task automatic push(input int st, input logic cont);
        exp_t e;
        e.vec = exp_vec(st, cur_ir);
        e.cont = cont;
        q.push_back(e);
    endtask

    task automatic push_n(input int st, input int n);
        for (int i = 0; i < n; i++) push(st, 1'b0);
    endtask

    // Pop and compare one entry per cycle; Continue is driven from the entry.
    task automatic drain(input string tag);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(tag, obs_vec, e.vec);
            Continue = e.cont;
            @(negedge Clk);
        end
    endtask

    // Called at the falling edge of an instruction's S18 cycle.
    task automatic do_instr(input string tag, input logic [15:0] ir, input logic ben);
        IR = ir; BEN = ben; cur_ir = ir;
        push(S18, 1'b0); push_n(S33, MW); push(S35, 1'b0); push(S32, 1'b0);
        case (ir[15:12])
            4'b0001: push(S1, 1'b0);
            4'b0101: push(S5, 1'b0);
            4'b1001: push(S9, 1'b0);
            4'b0000: begin push(S0, 1'b0); if (ben) push(S22, 1'b0); end
            4'b1100: push(S12, 1'b0);
            4'b0100: if (ir[11]) begin push(S4, 1'b0); push(S21, 1'b0); end
            4'b0110: begin push(S6, 1'b0); push_n(S25, MW); push(S27, 1'b0); end
            4'b0111: begin push(S7, 1'b0); push(S23, 1'b0); push_n(S16, MW); end
`ifdef LC3_ISDU_PAUSE_EN
            4'b1101: begin
                push(S13a, 1'b0); push(S13a, 1'b0); push(S13a, 1'b1);
                push(S13b, 1'b1); push(S13b, 1'b0);
            end
`endif
            default: ;
        endcase
        drain(tag);
    endtask

    initial begin
        Reset_al = 1'b0; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; IR = 16'h0000;
        cur_ir = 16'h0000;
        #1 check("reset_zero", obs_vec, '0);
        @(negedge Clk);
        Reset_al = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("halted_idle", obs_vec, '0);
            @(negedge Clk);
        end
        Run = 1'b1;
        @(negedge Clk);

        // Interrupt a fetch in the middle of S33.
        IR = 16'h1042; cur_ir = 16'h1042;
        check("fetch_s18", obs_vec, exp_vec(S18, cur_ir));
        @(negedge Clk);
        check("fetch_s33", obs_vec, exp_vec(S33, cur_ir));
        #2 Reset_al = 1'b0;
        #1 check("async_reset", obs_vec, '0);
        @(negedge Clk);
        Reset_al = 1'b1; Run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("halted_after_reset", obs_vec, '0);
            @(negedge Clk);
        end
        Run = 1'b1;
        @(negedge Clk);

        do_instr("add_reg", 16'h1042, 1'b0);
        Run = 1'b0;
        do_instr("add_imm", 16'h1062, 1'b0);
        do_instr("and", 16'h5042, 1'b0);
        do_instr("not", 16'h907F, 1'b0);
        do_instr("br_not_taken", 16'h0402, 1'b0);
        do_instr("br_taken", 16'h0402, 1'b1);
        do_instr("jmp", 16'hC080, 1'b0);
        do_instr("jsr", 16'h4801, 1'b0);
        do_instr("jsrr_illegal", 16'h4040, 1'b0);
        do_instr("ldr", 16'h6042, 1'b0);
        do_instr("str", 16'h7042, 1'b0);
        do_instr("illegal_8", 16'h8000, 1'b0);
        do_instr("pause", 16'hD00F, 1'b0);
        do_instr("add_after", 16'h1042, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the stimulus is fixed-length, so this only fires on a bench hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d compared", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
